// File: rtl/sync_fifo_pro.sv
// Single-clock FIFO with optional first-word-fall-through, occupancy count,
// almost-full/almost-empty thresholds and overflow/underflow error pulses.
module sync_fifo_pro #(
  parameter int DATA_WIDTH    = 8,
  parameter int DATA_DEPTH    = 16,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DATA_WIDTH-1:0]          data_in,
  input  logic                           wr_en,
  input  logic                           rd_en,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic                           fifo_full,
  output logic                           fifo_empty,
  output logic                           almost_full,
  output logic                           almost_empty,
  output logic [$clog2(DATA_DEPTH):0]    data_count,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int AW = $clog2(DATA_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DATA_DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AFULL_THRESH);
  localparam logic [AW:0] AE_C    = (AW+1)'(AEMPTY_THRESH);

  if (DATA_WIDTH < 1 || DATA_DEPTH < 2 || (DATA_DEPTH & (DATA_DEPTH-1)) != 0 ||
      (FWFT != 0 && FWFT != 1) ||
      AFULL_THRESH < 1 || AFULL_THRESH > DATA_DEPTH ||
      AEMPTY_THRESH < 0 || AEMPTY_THRESH > DATA_DEPTH-1) begin : g_param_err
    $error("sync_fifo_pro: illegal parameter combination");
  end

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr, cnt_q;
  logic                  wr_acc, rd_acc;

  // Flags come from the count alone, so pointer wrap never aliases full/empty.
  assign fifo_full    = (cnt_q == DEPTH_C);
  assign fifo_empty   = (cnt_q == '0);
  assign almost_full  = (cnt_q >= AF_C);
  assign almost_empty = (cnt_q <= AE_C);
  assign data_count   = cnt_q;

  assign wr_acc = wr_en & ~fifo_full;
  assign rd_acc = rd_en & ~fifo_empty;

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt_q     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      overflow  <= wr_en & fifo_full;
      underflow <= rd_en & fifo_empty;
    end
  end

  if (FWFT == 0) begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      dout_q <= '0;
      else if (rd_acc) dout_q <= mem[rd_ptr[AW-1:0]];
    end
    assign data_out = dout_q;
  end else begin : g_fwft
    // Head word is shown directly; rd_en pops what is displayed.
    assign data_out = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];
  end

endmodule

// File: tb/tb_sync_fifo_pro.sv
// Directed bench for sync_fifo_pro: a standard and an FWFT instance share
// stimulus and are checked each cycle against a queue model of the FIFO.
module tb_sync_fifo_pro;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AW = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic wr_en = 1'b0;
  logic rd_en = 1'b0;

  logic [DW-1:0] dout0, dout1;
  logic full0, empty0, af0, ae0, ovf0, udf0;
  logic full1, empty1, af1, ae1, ovf1, udf1;
  logic [AW:0] cnt0, cnt1;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sync_fifo_pro #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .FWFT(0),
                  .AFULL_THRESH(12), .AEMPTY_THRESH(2)) u_std (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(dout0), .fifo_full(full0), .fifo_empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .data_count(cnt0),
    .overflow(ovf0), .underflow(udf0));

  sync_fifo_pro #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .FWFT(1),
                  .AFULL_THRESH(12), .AEMPTY_THRESH(2)) u_fwft (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(dout1), .fifo_full(full1), .fifo_empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .data_count(cnt1),
    .overflow(ovf1), .underflow(udf1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: contents as a queue, plus the registered outputs of each mode.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout0;
  logic m_ovf, m_udf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_dout0 = '0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      automatic bit was_full = (q.size() == DEPTH);
      automatic bit was_empty = (q.size() == 0);
      m_ovf = wr_en && was_full;
      m_udf = rd_en && was_empty;
      if (rd_en && !was_empty) m_dout0 = q.pop_front();
      if (wr_en && !was_full) q.push_back(data_in);
    end
  end

  always @(negedge clk) begin
    automatic int n = q.size();
    automatic logic [DW-1:0] head = (n == 0) ? '0 : q[0];
    chk("count0", 32'(cnt0), n);
    chk("count1", 32'(cnt1), n);
    chk("full0", 32'(full0), 32'(n == DEPTH));
    chk("full1", 32'(full1), 32'(n == DEPTH));
    chk("empty0", 32'(empty0), 32'(n == 0));
    chk("empty1", 32'(empty1), 32'(n == 0));
    chk("afull0", 32'(af0), 32'(n >= 12));
    chk("afull1", 32'(af1), 32'(n >= 12));
    chk("aempty0", 32'(ae0), 32'(n <= 2));
    chk("aempty1", 32'(ae1), 32'(n <= 2));
    chk("ovf0", 32'(ovf0), 32'(m_ovf));
    chk("ovf1", 32'(ovf1), 32'(m_ovf));
    chk("udf0", 32'(udf0), 32'(m_udf));
    chk("udf1", 32'(udf1), 32'(m_udf));
    chk("dout_std", 32'(dout0), 32'(m_dout0));
    chk("dout_fwft", 32'(dout1), 32'(head));
  end

  // Advance one edge; outputs are then stable until the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("rst_count", 32'(cnt0), 0);
    chk("rst_empty", 32'(empty0), 1);
    chk("rst_full", 32'(full0), 0);
    chk("rst_ae", 32'(ae0), 1);
    chk("rst_af", 32'(af0), 0);
    chk("rst_dout", 32'(dout0), 0);
    chk("rst_dout_fwft", 32'(dout1), 0);
    #12 rst_n = 1'b1;
    step();

    // Fill 0x01..0x10, then drain
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; data_in = DW'(i);
      step();
      if (i == 11) chk("t1_af_at11", 32'(af0), 0);
      if (i == 12) chk("t1_af_at12", 32'(af0), 1);
    end
    wr_en = 1'b0;
    chk("t1_full", 32'(full0), 1);
    chk("t1_count16", 32'(cnt0), 16);
    for (int i = 1; i <= 16; i++) begin
      rd_en = 1'b1;
      step();
      chk("t1_rd_data", 32'(dout0), i);
    end
    rd_en = 1'b0;
    chk("t1_empty", 32'(empty0), 1);

    // Overflow on full, underflow on empty
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; data_in = DW'(8'h20 + i);
      step();
    end
    data_in = 8'hAA;
    step();
    chk("t2_ovf", 32'(ovf0), 1);
    chk("t2_cnt", 32'(cnt0), 16);
    wr_en = 1'b0;
    step();
    chk("t2_ovf_clr", 32'(ovf0), 0);
    rd_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("t2_rd_data", 32'(dout0), 8'h20 + i);
    end
    step();
    chk("t2_udf", 32'(udf0), 1);
    chk("t2_dout_hold", 32'(dout0), 8'h30);
    rd_en = 1'b0;
    step();
    chk("t2_udf_clr", 32'(udf0), 0);

    // Steady count of 8 with simultaneous read/write across pointer wraps
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; data_in = DW'(8'h40 + i);
      step();
    end
    rd_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      data_in = DW'(8'h48 + i);
      step();
      chk("t3_cnt8", 32'(cnt0), 8);
      chk("t3_order", 32'(dout0), 8'h40 + i);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 8; i++) step();
    rd_en = 1'b0;
    chk("t3_drained", 32'(empty0), 1);
    chk("t3_last", 32'(dout0), 8'h40 + 47);

    // FWFT: write into empty shows next cycle, pop clears
    wr_en = 1'b1; data_in = 8'h5A;
    step();
    wr_en = 1'b0;
    chk("t4_fwft_empty", 32'(empty1), 0);
    chk("t4_fwft_data", 32'(dout1), 8'h5A);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("t4_fwft_empty2", 32'(empty1), 1);
    chk("t4_fwft_zero", 32'(dout1), 0);

    // Almost-empty threshold, then async reset mid-burst
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; data_in = DW'(8'h60 + i);
      step();
    end
    wr_en = 1'b0; rd_en = 1'b1;
    step(); step();
    chk("t5_ae_cnt3", 32'(ae0), 0);
    step();
    chk("t5_ae_cnt2", 32'(ae0), 1);
    rd_en = 1'b0; wr_en = 1'b1; data_in = 8'h77;
    step(); step();
    #2 rst_n = 1'b0;
    wr_en = 1'b0;
    #1;
    chk("t5_rst_cnt", 32'(cnt0), 0);
    chk("t5_rst_empty", 32'(empty0), 1);
    chk("t5_rst_dout", 32'(dout0), 0);
    chk("t5_rst_dout_fwft", 32'(dout1), 0);
    chk("t5_rst_ae", 32'(ae0), 1);
    #10 rst_n = 1'b1;
    wr_en = 1'b1; data_in = 8'h33;
    step();
    wr_en = 1'b0;
    chk("t5_fwft_33", 32'(dout1), 8'h33);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("t5_std_33", 32'(dout0), 8'h33);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
